// File: rtl/decim_sched.sv
// Two-channel decimating averager: round-robin arbitration into one shared
// accumulate-and-shift datapath feeding a single-entry output register.
module decim_sched #(
  parameter int DATA_SIZE = 24,
  parameter int MAX_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           log2_factor,
  input  logic                 left_valid,
  input  logic [DATA_SIZE-1:0] left_data,
  output logic                 left_ready,
  input  logic                 right_valid,
  input  logic [DATA_SIZE-1:0] right_data,
  output logic                 right_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_channel,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int ACC_W = DATA_SIZE + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [2:0] MAX_F = 3'(MAX_LOG2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] block_len(input logic [2:0] f);
    return CNT_W'(1) << f;
  endfunction

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_SIZE-1:0] d);
    return {{MAX_LOG2{d[DATA_SIZE-1]}}, d};
  endfunction

  // Arithmetic shift floors toward minus infinity; the mean always fits DATA_SIZE.
  function automatic logic [DATA_SIZE-1:0] scale(input logic signed [ACC_W-1:0] s,
                                                 input logic [2:0] f);
    logic signed [ACC_W-1:0] t;
    t = s >>> f;
    return DATA_SIZE'(t);
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  logic [2:0]             factor_r;
  logic [ACC_W-1:0]       acc_l_r;
  logic [ACC_W-1:0]       acc_r_r;
  logic [CNT_W-1:0]       cnt_l_r;
  logic [CNT_W-1:0]       cnt_r_r;
  logic                   ptr_r;
  logic                   out_valid_r;
  logic [DATA_SIZE-1:0]   out_data_r;
  logic                   out_channel_r;
  logic                   cfg_err_r;

  logic                   stall_s;
  logic                   done_l_s;
  logic                   done_r_s;
  logic                   can_l_s;
  logic                   can_r_s;
  logic                   grant_l_s;
  logic                   grant_r_s;
  logic [ACC_W-1:0]       acc_sel_s;
  logic [DATA_SIZE-1:0]   data_sel_s;
  logic [CNT_W-1:0]       cnt_sel_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                   done_s;
  logic                   load_s;
  logic [DATA_SIZE-1:0]   result_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = ARM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARM: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        if (!out_valid_r || out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Completion lookahead: a block-finishing grant needs room in the output register
  always_comb begin
    stall_s  = out_valid_r & ~out_ready;
    done_l_s = ((cnt_l_r + CNT_W'(1)) == block_len(factor_r));
    done_r_s = ((cnt_r_r + CNT_W'(1)) == block_len(factor_r));
    can_l_s  = left_valid & ~(done_l_s & stall_s);
    can_r_s  = right_valid & ~(done_r_s & stall_s);
  end

  // Round-robin arbiter; ptr_r=1 means right is preferred next
  always_comb begin
    grant_l_s = 1'b0;
    grant_r_s = 1'b0;
    if (state_r == RUN) begin
      if (can_l_s && can_r_s) begin
        grant_l_s = ~ptr_r;
        grant_r_s = ptr_r;
      end else begin
        grant_l_s = can_l_s;
        grant_r_s = can_r_s;
      end
    end else begin
      grant_l_s = 1'b0;
      grant_r_s = 1'b0;
    end
  end

  // Shared adder serving whichever channel holds the grant
  always_comb begin
    acc_sel_s  = grant_r_s ? acc_r_r    : acc_l_r;
    data_sel_s = grant_r_s ? right_data : left_data;
    cnt_sel_s  = grant_r_s ? cnt_r_r    : cnt_l_r;
    sum_s      = acc_sel_s + sext(data_sel_s);
    cnt_inc_s  = cnt_sel_s + CNT_W'(1);
    done_s     = (cnt_inc_s == block_len(factor_r));
    load_s     = (grant_l_s | grant_r_s) & done_s;
    result_s   = scale(sum_s, factor_r);
  end

  // Factor latch, sticky config error, accumulators, counts and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      factor_r  <= 3'd0;
      cfg_err_r <= 1'b0;
      acc_l_r   <= '0;
      acc_r_r   <= '0;
      cnt_l_r   <= '0;
      cnt_r_r   <= '0;
      ptr_r     <= 1'b0;
    end else begin
      case (state_r)
        ARM: begin
          factor_r  <= (log2_factor > MAX_F) ? MAX_F : log2_factor;
          cfg_err_r <= cfg_err_r | (log2_factor > MAX_F);
          acc_l_r   <= '0;
          acc_r_r   <= '0;
          cnt_l_r   <= '0;
          cnt_r_r   <= '0;
          ptr_r     <= 1'b0;
        end
        RUN: begin
          if (grant_l_s) begin
            ptr_r   <= 1'b1;
            acc_l_r <= done_s ? '0 : sum_s;
            cnt_l_r <= done_s ? '0 : cnt_inc_s;
          end else if (grant_r_s) begin
            ptr_r   <= 1'b0;
            acc_r_r <= done_s ? '0 : sum_s;
            cnt_r_r <= done_s ? '0 : cnt_inc_s;
          end else begin
            ptr_r <= ptr_r;
          end
        end
        FLUSH: begin
          acc_l_r <= '0;
          acc_r_r <= '0;
          cnt_l_r <= '0;
          cnt_r_r <= '0;
        end
        default: begin
          factor_r <= factor_r;
        end
      endcase
    end
  end

  // Single-entry output register, refillable in the cycle it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_channel_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r   <= 1'b1;
      out_data_r    <= result_s;
      out_channel_r <= grant_r_s;
    end else if (out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign left_ready  = grant_l_s;
  assign right_ready = grant_r_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_channel = out_channel_r;
  assign busy        = (state_r != IDLE);
  assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_decim_sched.sv
// Directed bench for decim_sched: hand-computed averages, arbitration order,
// back-pressure, clamping, flush and reset behaviour.
module tb_decim_sched;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  log2_factor;
  logic        left_valid;
  logic [23:0] left_data;
  logic        left_ready;
  logic        right_valid;
  logic [23:0] right_data;
  logic        right_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_channel;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  decim_sched #(.DATA_SIZE(24), .MAX_LOG2(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .log2_factor(log2_factor),
    .left_valid(left_valid), .left_data(left_data), .left_ready(left_ready),
    .right_valid(right_valid), .right_data(right_data), .right_ready(right_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel), .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_l(input logic [23:0] d, input string tag);
    left_valid = 1'b1;
    left_data  = d;
    #1;
    check(tag, {31'd0, left_ready}, 32'd1);
    tick();
    left_valid = 1'b0;
  endtask

  task automatic send_r(input logic [23:0] d, input string tag);
    right_valid = 1'b1;
    right_data  = d;
    #1;
    check(tag, {31'd0, right_ready}, 32'd1);
    tick();
    right_valid = 1'b0;
  endtask

  // Leave RUN through FLUSH/IDLE and arm with a new factor
  task automatic rearm(input logic [2:0] f);
    enable      = 1'b0;
    left_valid  = 1'b0;
    right_valid = 1'b0;
    tick();
    tick();
    check("rearm_idle", {31'd0, busy}, 32'd0);
    log2_factor = f;
    enable      = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; log2_factor = 3'd0; out_ready = 1'b1;
    left_valid = 1'b0; left_data = 24'd0; right_valid = 1'b0; right_data = 24'd0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_readies", {30'd0, left_ready, right_ready}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_out_channel", {31'd0, out_channel}, 32'd0);
    rst = 1'b0;

    // factor 2, left only: 4,8,12,16 -> 10
    log2_factor = 3'd2;
    enable = 1'b1;
    tick();
    check("arm_busy", {31'd0, busy}, 32'd1);
    check("arm_no_ready", {30'd0, left_ready, right_ready}, 32'd0);
    tick();
    send_l(24'd4, "f2_s1");
    send_l(24'd8, "f2_s2");
    send_l(24'd12, "f2_s3");
    check("f2_no_early_out", {31'd0, out_valid}, 32'd0);
    send_l(24'd16, "f2_s4");
    check("f2_out_valid", {31'd0, out_valid}, 32'd1);
    check("f2_out_data", {8'd0, out_data}, 32'd10);
    check("f2_out_channel", {31'd0, out_channel}, 32'd0);
    tick();
    check("f2_drained", {31'd0, out_valid}, 32'd0);

    // factor 1, both valid continuously: L,R,L,R
    rearm(3'd1);
    left_valid = 1'b1; right_valid = 1'b1;
    left_data = 24'd2; right_data = 24'd10;
    #1;
    check("rr_g1", {30'd0, left_ready, right_ready}, 32'd2);
    tick();
    left_data = 24'd4;
    check("rr_g2", {30'd0, left_ready, right_ready}, 32'd1);
    tick();
    right_data = 24'd30;
    check("rr_g3", {30'd0, left_ready, right_ready}, 32'd2);
    tick();
    check("rr_out1_data", {8'd0, out_data}, 32'd3);
    check("rr_out1_chan", {31'd0, out_channel}, 32'd0);
    check("rr_g4", {30'd0, left_ready, right_ready}, 32'd1);
    tick();
    check("rr_out2_valid", {31'd0, out_valid}, 32'd1);
    check("rr_out2_data", {8'd0, out_data}, 32'd20);
    check("rr_out2_chan", {31'd0, out_channel}, 32'd1);
    left_valid = 1'b0; right_valid = 1'b0;
    tick();
    check("rr_drained", {31'd0, out_valid}, 32'd0);

    // floor on negatives, no overflow at full scale
    send_l(24'hFFFFF8, "neg_s1");
    send_l(24'hFFFFF9, "neg_s2");
    check("neg_floor", {8'd0, out_data}, 32'h00FFFFF8);
    send_l(24'h7FFFFF, "max_s1");
    send_l(24'h7FFFFF, "max_s2");
    check("max_no_ovf", {8'd0, out_data}, 32'h007FFFFF);
    tick();

    // back-pressure: completing grant withheld while result is held
    out_ready = 1'b0;
    send_l(24'd6, "bp_s1");
    send_l(24'd8, "bp_s2");
    check("bp_hold_data", {8'd0, out_data}, 32'd7);
    send_l(24'd100, "bp_s3");
    left_valid = 1'b1; left_data = 24'd200;
    #1;
    check("bp_ready_low", {31'd0, left_ready}, 32'd0);
    tick();
    check("bp_still_valid", {31'd0, out_valid}, 32'd1);
    check("bp_stable_data", {8'd0, out_data}, 32'd7);
    check("bp_ready_low2", {31'd0, left_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_resume", {31'd0, left_ready}, 32'd1);
    tick();
    check("bp_new_data", {8'd0, out_data}, 32'd150);
    check("bp_new_valid", {31'd0, out_valid}, 32'd1);
    left_valid = 1'b0;
    tick();

    // clamp 7 -> 4: 1..16 averages to 8
    rearm(3'd7);
    check("clamp_cfg_err", {31'd0, cfg_err}, 32'd1);
    for (int i = 1; i <= 15; i++) send_l(24'(i), "clamp_s");
    check("clamp_no_early_out", {31'd0, out_valid}, 32'd0);
    send_l(24'd16, "clamp_s16");
    check("clamp_out_valid", {31'd0, out_valid}, 32'd1);
    check("clamp_out_data", {8'd0, out_data}, 32'd8);

    // factor 0 pass-through on both channels; cfg_err stays sticky
    rearm(3'd0);
    check("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);
    send_r(24'h123456, "pass_r");
    check("pass_r_data", {8'd0, out_data}, 32'h00123456);
    check("pass_r_chan", {31'd0, out_channel}, 32'd1);
    send_l(24'h800000, "pass_l");
    check("pass_l_data", {8'd0, out_data}, 32'h00800000);
    check("pass_l_chan", {31'd0, out_channel}, 32'd0);
    tick();

    // flush discards a partial block; enable during FLUSH is ignored
    rearm(3'd2);
    send_l(24'd1, "fl_s1");
    send_l(24'd2, "fl_s2");
    send_l(24'd3, "fl_s3");
    enable = 1'b0;
    tick();
    enable = 1'b1; left_valid = 1'b1; left_data = 24'd4;
    #1;
    check("fl_busy", {31'd0, busy}, 32'd1);
    check("fl_no_grant", {31'd0, left_ready}, 32'd0);
    check("fl_no_out", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_idle", {31'd0, busy}, 32'd0);
    left_valid = 1'b0;
    tick();
    tick();
    send_l(24'd4, "fl_r1");
    send_l(24'd4, "fl_r2");
    send_l(24'd4, "fl_r3");
    check("fl_fresh_no_early", {31'd0, out_valid}, 32'd0);
    send_l(24'd4, "fl_r4");
    check("fl_fresh_data", {8'd0, out_data}, 32'd4);

    // reset while a result is pending
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_l(24'd9, "rst_mid_s");
    check("rst_mid_pending", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_mid_data", {8'd0, out_data}, 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    tick();
    check("rst_mid_quiet", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
